// File: rtl/obi_tmr_voter.sv
// ---------------------------------------------------------------------------
// obi_tmr_voter
//
// Purpose:
//   Majority voter for the data OBI path of a triple-core lockstep system.
//   The three per-core requests are voted bit-wise. The voted request is
//   forwarded to a single OBI master port. The bus response is broadcast
//   back to all three cores. Cores that disagree with the vote are flagged.
//   A fatal flag is raised when a request is pending with no majority.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   core_req_i   data requests from cores 0..2
//   core_resp_o  responses broadcast to cores 0..2
//   bus_req_o    voted request toward the bus (registered)
//   bus_resp_i   bus response
//   err_cnt_o    per-core saturating mismatch counters (optional feature)
//   mismatch_o   sticky per-core disagreement flags
//   fatal_o      sticky no-majority flag
//   clear_i      synchronous clear of flags and counters
//
// Optional feature:
//   Define TMR_VOTER_ERR_CNT_EN to add err_cnt_o and the per-core
//   saturating counters of width ERR_CNT_WIDTH.
// ---------------------------------------------------------------------------

package obi_tmr_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_tmr_voter
    import obi_tmr_pkg::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  obi_req_t  [2:0]                   core_req_i,
    output obi_resp_t [2:0]                   core_resp_o,
    output obi_req_t                          bus_req_o,
    input  obi_resp_t                         bus_resp_i,
`ifdef TMR_VOTER_ERR_CNT_EN
    output logic      [2:0][ERR_CNT_WIDTH-1:0] err_cnt_o,
`endif
    output logic      [2:0]                   mismatch_o,
    output logic                              fatal_o,
    input  logic                              clear_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    localparam int unsigned ReqBits = $bits(obi_req_t);

    state_e               state_q;
    obi_req_t             hold_q;
    obi_req_t             vote;
    logic [ReqBits-1:0]   bundle0;
    logic [ReqBits-1:0]   bundle1;
    logic [ReqBits-1:0]   bundle2;
    logic                 majority;
    logic [2:0]           disagree;
    logic                 sample;
    logic [2:0]           mismatch_q;
    logic                 fatal_q;

    assign bundle0 = core_req_i[0];
    assign bundle1 = core_req_i[1];
    assign bundle2 = core_req_i[2];

    // Bit-wise 2-of-3 vote over the whole request bundle. A majority exists
    // as soon as any two cores present identical bundles.
    always_comb begin
        vote     = obi_req_t'((bundle0 & bundle1) | (bundle0 & bundle2) | (bundle1 & bundle2));
        majority = (bundle0 == bundle1) || (bundle0 == bundle2) || (bundle1 == bundle2);
        for (int k = 0; k < 3; k++) begin
            disagree[k] = (core_req_i[k] != vote);
        end
    end

    // Disagreements only count when a new request is being accepted from
    // IDLE; during REQ/RESP the cores are free to move on.
    assign sample = (state_q == IDLE) && vote.req;

    // Transaction FSM. The hold register is also the registered bus request:
    // its req bit is set on capture and dropped on gnt, so bus_req_o.req is
    // high exactly while in REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vote.req && majority) begin
                        hold_q  <= vote;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus_resp_i.gnt) begin
                        hold_q.req <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (bus_resp_i.rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; clear wins over a set in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch_q <= '0;
            fatal_q    <= 1'b0;
        end else if (clear_i) begin
            mismatch_q <= '0;
            fatal_q    <= 1'b0;
        end else if (sample) begin
            mismatch_q <= mismatch_q | disagree;
            if (!majority) begin
                fatal_q <= 1'b1;
            end
        end
    end

`ifdef TMR_VOTER_ERR_CNT_EN
    logic [2:0][ERR_CNT_WIDTH-1:0] err_cnt_q;

    // Per-core saturating counters. A no-majority request charges all
    // three cores since none of them can be trusted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (clear_i) begin
            err_cnt_q <= '0;
        end else if (sample) begin
            for (int k = 0; k < 3; k++) begin
                if ((!majority || disagree[k]) && (err_cnt_q[k] != {ERR_CNT_WIDTH{1'b1}})) begin
                    err_cnt_q[k] <= err_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    // Without the counters the width parameter has no consumer.
    if (ERR_CNT_WIDTH == 0) begin : g_no_counters
    end
`endif

    // Response broadcast: handshakes are only forwarded in the state that
    // expects them, so stray gnt/rvalid never reach the cores.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            core_resp_o[k].gnt    = (state_q == REQ)  && bus_resp_i.gnt;
            core_resp_o[k].rvalid = (state_q == RESP) && bus_resp_i.rvalid;
            core_resp_o[k].rdata  = bus_resp_i.rdata;
        end
    end

    assign bus_req_o  = hold_q;
    assign mismatch_o = mismatch_q;
    assign fatal_o    = fatal_q;

endmodule

// File: tb/tb_obi_tmr_voter.sv
// ---------------------------------------------------------------------------
// tb_obi_tmr_voter
//
// Self-checking bench for obi_tmr_voter. A transaction-level reference
// model tracks what the voter must do. Every cycle, on the falling edge,
// the model is compared against the DUT outputs. The stimulus is directed
// scenarios followed by randomised traffic.
// Define TMR_VOTER_ERR_CNT_EN for both bench and RTL to cover the counters.
// ---------------------------------------------------------------------------

module tb_obi_tmr_voter;
    import obi_tmr_pkg::*;

    localparam int W       = 8;
    localparam int CNT_MAX = (1 << W) - 1;

    logic                clk_i  = 1'b0;
    logic                rst_ni = 1'b0;
    obi_req_t  [2:0]     core_req = '0;
    obi_resp_t [2:0]     core_resp;
    obi_req_t            bus_req;
    obi_resp_t           bus_resp = '0;
    logic      [2:0]     mismatch;
    logic                fatal;
    logic                clear = 1'b0;
`ifdef TMR_VOTER_ERR_CNT_EN
    logic [2:0][W-1:0]   err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    obi_tmr_voter #(.ERR_CNT_WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .core_req_i  (core_req),
        .core_resp_o (core_resp),
        .bus_req_o   (bus_req),
        .bus_resp_i  (bus_resp),
`ifdef TMR_VOTER_ERR_CNT_EN
        .err_cnt_o   (err_cnt),
`endif
        .mismatch_o  (mismatch),
        .fatal_o     (fatal),
        .clear_i     (clear)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point: counts the check and reports on failure.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Majority per bit by counting ones across the three cores.
    function automatic obi_req_t vote_of(input obi_req_t a, input obi_req_t b, input obi_req_t c);
        logic [$bits(obi_req_t)-1:0] va, vb, vc, v;
        va = a; vb = b; vc = c; v = '0;
        for (int i = 0; i < $bits(obi_req_t); i++) begin
            int ones;
            ones = int'(va[i]) + int'(vb[i]) + int'(vc[i]);
            v[i] = (ones >= 2);
        end
        return obi_req_t'(v);
    endfunction

    function automatic bit has_majority(input obi_req_t a, input obi_req_t b, input obi_req_t c);
        return (a == b) || (a == c) || (b == c);
    endfunction

    function automatic obi_req_t rand_req();
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.be    = 4'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // phase 0: waiting for a request, 1: request on the bus awaiting gnt,
    // 2: granted, awaiting rvalid.
    int         m_phase;
    obi_req_t   m_hold;
    logic [2:0] m_mis;
    logic       m_fatal;
    int         m_cnt [3];
    obi_req_t   m_vote;
    bit         m_maj;

    assign m_vote = vote_of(core_req[0], core_req[1], core_req[2]);
    assign m_maj  = has_majority(core_req[0], core_req[1], core_req[2]);

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase <= 0;
            m_hold  <= '0;
            m_mis   <= '0;
            m_fatal <= 1'b0;
            for (int k = 0; k < 3; k++) m_cnt[k] <= 0;
        end else begin
            if (m_phase == 0 && m_vote.req) begin
                if (m_maj) begin
                    m_hold  <= m_vote;
                    m_phase <= 1;
                end else begin
                    m_fatal <= 1'b1;
                end
                for (int k = 0; k < 3; k++) begin
                    if (core_req[k] != m_vote) m_mis[k] <= 1'b1;
                    if (!m_maj || core_req[k] != m_vote)
                        m_cnt[k] <= (m_cnt[k] >= CNT_MAX) ? CNT_MAX : m_cnt[k] + 1;
                end
            end else if (m_phase == 1 && bus_resp.gnt) begin
                m_phase <= 2;
            end else if (m_phase == 2 && bus_resp.rvalid) begin
                m_phase <= 0;
            end
            if (clear) begin
                m_mis   <= '0;
                m_fatal <= 1'b0;
                for (int k = 0; k < 3; k++) m_cnt[k] <= 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            checkOutput("reset bus_req", bus_req, '0);
            checkOutput("reset gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, 3'b000);
            checkOutput("reset rvalid", {core_resp[2].rvalid, core_resp[1].rvalid, core_resp[0].rvalid}, 3'b000);
            checkOutput("reset mismatch", mismatch, 3'b000);
            checkOutput("reset fatal", fatal, 1'b0);
        end else begin
            logic exp_gnt, exp_rv;
            exp_gnt = (m_phase == 1) && bus_resp.gnt;
            exp_rv  = (m_phase == 2) && bus_resp.rvalid;
            checkOutput("bus_req.req", bus_req.req, m_phase == 1);
            if (m_phase == 1) checkOutput("bus_req bundle", bus_req, m_hold);
            checkOutput("core gnt", {core_resp[2].gnt, core_resp[1].gnt, core_resp[0].gnt}, {3{exp_gnt}});
            checkOutput("core rvalid", {core_resp[2].rvalid, core_resp[1].rvalid, core_resp[0].rvalid}, {3{exp_rv}});
            for (int k = 0; k < 3; k++) checkOutput("core rdata", core_resp[k].rdata, bus_resp.rdata);
            checkOutput("mismatch", mismatch, m_mis);
            checkOutput("fatal", fatal, m_fatal);
        end
`ifdef TMR_VOTER_ERR_CNT_EN
        for (int k = 0; k < 3; k++) checkOutput("err_cnt", err_cnt[k], m_cnt[k]);
`endif
    end

    // Event recorders used by the directed scenarios.
    int       cyc = 0;
    logic     rec_prev_req = 1'b0;
    int       rec_rise_cyc = -1;
    int       rec_rises = 0;
    obi_req_t rec_bus = '0;
    int       rec_gnt = 0;
    int       rec_rv = 0;
    logic [31:0] rec_rdata = '0;

    always @(negedge clk_i) begin
        cyc          <= cyc + 1;
        rec_prev_req <= bus_req.req;
        if (bus_req.req && !rec_prev_req) begin
            rec_rise_cyc <= cyc + 1;
            rec_rises    <= rec_rises + 1;
            rec_bus      <= bus_req;
        end
        if (core_resp[0].gnt && core_resp[1].gnt && core_resp[2].gnt) rec_gnt <= rec_gnt + 1;
        if (core_resp[0].rvalid && core_resp[1].rvalid && core_resp[2].rvalid) begin
            rec_rv    <= rec_rv + 1;
            rec_rdata <= core_resp[1].rdata;
        end
    end

    // ---------------- stimulus ----------------
    int exp_bus_cyc;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full core-side transaction with a bus responder that waits
    // gnt_dly cycles in REQ and rv_dly cycles in RESP. With noise set,
    // stray handshakes and changing core requests appear where they must
    // be ignored.
    task automatic applyStimulus(input obi_req_t r0, input obi_req_t r1, input obi_req_t r2,
                                 input int gnt_dly, input int rv_dly,
                                 input logic [31:0] rdata, input bit noise, input bit clr);
        obi_req_t v;
        bit       maj;
        core_req[0] = r0;
        core_req[1] = r1;
        core_req[2] = r2;
        clear       = clr;
        bus_resp    = '0;
        bus_resp.rdata = $urandom;
        exp_bus_cyc = cyc + 2;
        v   = vote_of(r0, r1, r2);
        maj = has_majority(r0, r1, r2);
        tick();
        clear = 1'b0;
        if (!(v.req && maj)) begin
            core_req = '0;
            return;
        end
        repeat (gnt_dly) begin
            bus_resp.rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_resp.rdata  = $urandom;
            tick();
        end
        bus_resp.gnt    = 1'b1;
        bus_resp.rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        bus_resp.gnt    = 1'b0;
        bus_resp.rvalid = 1'b0;
        repeat (rv_dly) begin
            bus_resp.gnt   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_resp.rdata = $urandom;
            for (int k = 0; k < 3; k++) core_req[k] = noise ? rand_req() : '0;
            tick();
        end
        bus_resp.gnt    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = rdata;
        for (int k = 0; k < 3; k++) core_req[k] = noise ? rand_req() : '0;
        tick();
        bus_resp = '0;
        core_req = '0;
    endtask

    // Idle cycles: cores show garbage with req=0, bus throws stray handshakes.
    task automatic idleCycles(input int n);
        repeat (n) begin
            for (int k = 0; k < 3; k++) begin
                core_req[k]     = rand_req();
                core_req[k].req = 1'b0;
            end
            bus_resp.gnt    = 1'($urandom_range(0, 1));
            bus_resp.rvalid = 1'($urandom_range(0, 1));
            bus_resp.rdata  = $urandom;
            tick();
        end
        core_req = '0;
        bus_resp = '0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    obi_req_t a, b, c, base;
    int g0, v0, rises0;

    initial begin
        // Pin the model's vote with hand-computed values.
        a = '0; b = '0; c = '0;
        a.addr = 32'h3; b.addr = 32'h5; c.addr = 32'h6;
        checkOutput("model vote 3/5/6", vote_of(a, b, c).addr, 32'h7);
        a.addr = 32'h10; b.addr = 32'h20; c.addr = 32'h40;
        checkOutput("model vote 10/20/40", vote_of(a, b, c).addr, 32'h0);

        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // Three identical reads, gnt after 2 cycles, rvalid 3 after gnt.
        $display("[TB] identical read");
        base = '0; base.req = 1'b1; base.be = 4'hF; base.addr = 32'h1000_0040;
        g0 = rec_gnt; v0 = rec_rv;
        applyStimulus(base, base, base, 2, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("read latency", rec_rise_cyc, exp_bus_cyc);
        checkOutput("read addr", rec_bus.addr, 32'h1000_0040);
        checkOutput("read we", rec_bus.we, 1'b0);
        checkOutput("read gnt count", rec_gnt - g0, 1);
        checkOutput("read rvalid count", rec_rv - v0, 1);
        checkOutput("read rdata", rec_rdata, 32'hDEAD_BEEF);
        checkOutput("read mismatch", mismatch, 3'b000);

        // Core 1 write data differs.
        $display("[TB] write with core 1 disagreeing");
        base = '0; base.req = 1'b1; base.we = 1'b1; base.be = 4'hF; base.addr = 32'h2000;
        a = base; a.wdata = 32'h1;
        applyStimulus(base, a, base, 0, 1, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("write wdata", rec_bus.wdata, 32'h0);
        checkOutput("write we", rec_bus.we, 1'b1);
        checkOutput("write mismatch", mismatch, 3'b010);
`ifdef TMR_VOTER_ERR_CNT_EN
        checkOutput("write err_cnt1", err_cnt[1], 1);
`endif
        pulseClear();

        // No majority: three different addresses.
        $display("[TB] no majority");
        a = '0; a.req = 1'b1; b = a; c = a;
        a.addr = 32'h10; b.addr = 32'h20; c.addr = 32'h40;
        rises0 = rec_rises;
        applyStimulus(a, b, c, 0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("nomaj fatal", fatal, 1'b1);
        checkOutput("nomaj mismatch", mismatch, 3'b111);
        tick();
        checkOutput("nomaj no bus req", rec_rises - rises0, 0);
        pulseClear();
        @(negedge clk_i);
        checkOutput("nomaj fatal cleared", fatal, 1'b0);

        // Core 2 idle, cores 0/1 read.
        $display("[TB] core 2 silent");
        base = '0; base.req = 1'b1; base.be = 4'hF; base.addr = 32'h3000;
        g0 = rec_gnt; v0 = rec_rv;
        applyStimulus(base, base, '0, 1, 0, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("silent gnt count", rec_gnt - g0, 1);
        checkOutput("silent rvalid count", rec_rv - v0, 1);
        checkOutput("silent mismatch", mismatch, 3'b100);
        pulseClear();

        // Reset during REQ drops the bus request immediately.
        $display("[TB] reset mid transaction");
        base = '0; base.req = 1'b1; base.addr = 32'h4000;
        core_req = {base, base, base};
        tick();
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("reset in REQ drops req", bus_req.req, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        bus_resp.gnt = 1'b1;
        tick();
        bus_resp.gnt = 1'b0;
        core_req = '0;
        tick();
        // Now in RESP: reset, then a late rvalid must be dropped.
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("reset in RESP req", bus_req.req, 1'b0);
        tick();
        rst_ni = 1'b1;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hBAD0_BAD0;
        @(negedge clk_i);
        checkOutput("late rvalid dropped", core_resp[0].rvalid, 1'b0);
        tick();
        bus_resp = '0;
        g0 = rec_gnt; v0 = rec_rv;
        applyStimulus(base, base, base, 0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("after reset rvalid count", rec_rv - v0, 1);
        checkOutput("after reset rdata", rec_rdata, 32'h5555_AAAA);

        // 300 consecutive core-0 disagreements.
        $display("[TB] counter saturation");
        pulseClear();
        base = '0; base.req = 1'b1; base.we = 1'b1; base.addr = 32'h6000;
        a = base; a.wdata = 32'h8000_0000;
        for (int i = 0; i < 300; i++) applyStimulus(a, base, base, 0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("sat mismatch", mismatch, 3'b001);
`ifdef TMR_VOTER_ERR_CNT_EN
        checkOutput("sat err_cnt0", err_cnt[0], 8'hFF);
        checkOutput("sat err_cnt1", err_cnt[1], 8'h00);
`endif
        pulseClear();

        // Randomised traffic, checked every cycle by the model.
        $display("[TB] random traffic");
        for (int i = 0; i < 250; i++) begin
            int p;
            p = $urandom_range(0, 9);
            a = rand_req(); b = a; c = a;
            if (p >= 4 && p <= 6) begin
                obi_req_t d;
                int f;
                d = a;
                f = $urandom_range(0, 4);
                case (f)
                    0: d.req = 1'b0;
                    1: d.we = ~d.we;
                    2: d.be = d.be ^ 4'($urandom_range(1, 15));
                    3: d.addr = d.addr ^ (32'h1 << $urandom_range(0, 31));
                    default: d.wdata = d.wdata ^ (32'h1 << $urandom_range(0, 31));
                endcase
                case ($urandom_range(0, 2))
                    0: a = d;
                    1: b = d;
                    default: c = d;
                endcase
            end else if (p == 7) begin
                b = rand_req(); c = rand_req();
            end else if (p == 8) begin
                a.req = 1'b0; b.req = 1'b0; c.req = 1'b0;
                b.addr = $urandom;
            end else if (p == 9) begin
                b.req = 1'b0; c.req = 1'b0;
            end
            applyStimulus(a, b, c, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom, 1'b1, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
